// File: rtl/mdu_hilo.sv
// mdu_hilo: iterative multiply/divide unit with architectural HI/LO registers.
// MULT/MULTU use a radix-2 shift-add over WIDTH cycles. DIV/DIVU use restoring
// shift-subtract over WIDTH cycles. Both run on magnitudes, and the sign is
// corrected in FIN.
// Build option MDU_DIV_EN: when defined, the divider is built. When undefined,
// a divide op only pulses done one edge later and leaves HI/LO untouched.
module mdu_hilo #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] rs_val,
   input  logic [WIDTH-1:0] rt_val,
   input  logic             hi_we,
   input  logic             lo_we,
   input  logic [WIDTH-1:0] wd,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             div_q, div_d;     // latched op[1]
   logic             neg_q, neg_d;     // product/quotient must be negated
   logic [WIDTH-1:0] a_q, a_d;         // |rs| : multiplicand / dividend
   logic [WIDTH-1:0] acc_q, acc_d;     // upper product half / partial remainder
   logic [WIDTH-1:0] lsh_q, lsh_d;     // multiplier bits out, product/quotient bits in
   logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
   logic             done_q, done_d;

   // Signed ops (op[0]) take operand magnitudes at launch.
   logic             s_a, s_b;
   logic [WIDTH-1:0] mag_a, mag_b;
   assign s_a   = op[0] & rs_val[WIDTH-1];
   assign s_b   = op[0] & rt_val[WIDTH-1];
   assign mag_a = s_a ? (~rs_val + 1'b1) : rs_val;
   assign mag_b = s_b ? (~rt_val + 1'b1) : rt_val;

   // One shift-add step. The carry out of acc+a becomes the top bit after the shift.
   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] prod_mag, prod_res;
   assign mul_sum  = {1'b0, acc_q} + (lsh_q[0] ? {1'b0, a_q} : '0);
   assign prod_mag = {acc_q, lsh_q};
   assign prod_res = neg_q ? -prod_mag : prod_mag;

`ifdef MDU_DIV_EN
   logic             sa_q, sa_d;       // dividend sign: sign of the remainder
   logic             dz_q, dz_d;       // divide by zero
   logic [WIDTH-1:0] b_q, b_d;         // |rt| : divisor
   // One restoring step. trial[WIDTH] set means the subtract went negative.
   logic [WIDTH:0]   div_sh, div_tr;
   assign div_sh = {acc_q, lsh_q[WIDTH-1]};
   assign div_tr = div_sh - {1'b0, b_q};
   // busy covers RUN and FIN, 33 cycles for WIDTH=32.
   assign busy   = (state_q != IDLE);
`else
   // A divide op with no divider passes through FIN without raising busy.
   assign busy   = (state_q == RUN) | ((state_q == FIN) & ~div_q);
`endif

   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

   // Next-state, datapath step and HI/LO update.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      div_d   = div_q;
      neg_d   = neg_q;
      a_d     = a_q;
      acc_d   = acc_q;
      lsh_d   = lsh_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
`ifdef MDU_DIV_EN
      sa_d    = sa_q;
      dz_d    = dz_q;
      b_d     = b_q;
`endif
      case (state_q)
         IDLE: begin
            if (hi_we) hi_d = wd;
            if (lo_we) lo_d = wd;
            if (start) begin
               div_d   = op[1];
               neg_d   = s_a ^ s_b;
               a_d     = mag_a;
               acc_d   = '0;
               lsh_d   = op[1] ? mag_a : mag_b;
               cnt_d   = '0;
               state_d = RUN;
`ifdef MDU_DIV_EN
               sa_d    = s_a;
               dz_d    = (rt_val == '0);
               b_d     = mag_b;
`else
               if (op[1]) state_d = FIN;
`endif
            end
         end
         RUN: begin
`ifdef MDU_DIV_EN
            if (div_q) begin
               if (!div_tr[WIDTH]) begin
                  acc_d = div_tr[WIDTH-1:0];
                  lsh_d = {lsh_q[WIDTH-2:0], 1'b1};
               end else begin
                  acc_d = div_sh[WIDTH-1:0];
                  lsh_d = {lsh_q[WIDTH-2:0], 1'b0};
               end
            end else begin
               acc_d = mul_sum[WIDTH:1];
               lsh_d = {mul_sum[0], lsh_q[WIDTH-1:1]};
            end
`else
            acc_d = mul_sum[WIDTH:1];
            lsh_d = {mul_sum[0], lsh_q[WIDTH-1:1]};
`endif
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH-1)) state_d = FIN;
         end
         FIN: begin
            state_d = IDLE;
            done_d  = 1'b1;
            if (!div_q) begin
               hi_d = prod_res[2*WIDTH-1:WIDTH];
               lo_d = prod_res[WIDTH-1:0];
            end
`ifdef MDU_DIV_EN
            else if (dz_q) begin
               // Give back the original dividend. The magnitude is re-signed.
               hi_d = sa_q ? -a_q : a_q;
               lo_d = '1;
            end else begin
               hi_d = sa_q  ? -acc_q : acc_q;
               lo_d = neg_q ? -lsh_q : lsh_q;
            end
`endif
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers. Reset drops any operation in progress.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         div_q   <= 1'b0;
         neg_q   <= 1'b0;
         a_q     <= '0;
         acc_q   <= '0;
         lsh_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         done_q  <= 1'b0;
`ifdef MDU_DIV_EN
         sa_q    <= 1'b0;
         dz_q    <= 1'b0;
         b_q     <= '0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         div_q   <= div_d;
         neg_q   <= neg_d;
         a_q     <= a_d;
         acc_q   <= acc_d;
         lsh_q   <= lsh_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         done_q  <= done_d;
`ifdef MDU_DIV_EN
         sa_q    <= sa_d;
         dz_q    <= dz_d;
         b_q     <= b_d;
`endif
      end
   end

endmodule

// File: tb/tb_mdu_hilo.sv
// tb_mdu_hilo: self-checking bench for mdu_hilo. It works with or without
// MDU_DIV_EN. Without the divider, divide ops are expected to leave HI/LO as
// they were, with done one edge after start and busy never raised.
module tb_mdu_hilo;
   localparam int W = 32;
`ifdef MDU_DIV_EN
   localparam bit DIV = 1'b1;
`else
   localparam bit DIV = 1'b0;
`endif

   logic         clk, rst_n, start, hi_we, lo_we, busy, done;
   logic [1:0]   op;
   logic [W-1:0] rs_val, rt_val, wd, hi, lo;

   mdu_hilo #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .op(op),
      .rs_val(rs_val), .rt_val(rt_val), .hi_we(hi_we), .lo_we(lo_we),
      .wd(wd), .busy(busy), .done(done), .hi(hi), .lo(lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]   op;
      logic [W-1:0] rs, rt, ehi, elo;
   } vec_t;

   typedef struct {
      logic [W-1:0] hi, lo;
      int           lat, bsy;
   } exp_t;

   exp_t         sbq[$];
   logic [W-1:0] m_hi, m_lo;   // expected architectural HI/LO
   int           errors, checks;

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Call with clk low. Drives one start pulse across edge E0 and pushes the expected result.
   task automatic launch(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] eh, input logic [W-1:0] el);
      exp_t e;
      if (o[1] && !DIV) begin
         e.hi = m_hi; e.lo = m_lo; e.lat = 1; e.bsy = 0;
      end else begin
         e.hi = eh; e.lo = el; e.lat = W + 1; e.bsy = W + 1;
      end
      m_hi = e.hi; m_lo = e.lo;
      sbq.push_back(e);
      start = 1'b1; op = o; rs_val = a; rt_val = b;
      @(posedge clk);
      #1 start = 1'b0; rs_val = $urandom; rt_val = $urandom;
   endtask

   // Waits (bounded) for done, then pops the expectation and compares.
   task automatic finish_op(input string name);
      int   k, nb;
      bit   seen;
      exp_t e;
      nb = 0; seen = 1'b0;
      for (k = 0; k < 200; k++) begin
         @(negedge clk);
         if (busy) nb++;
         if (done) begin seen = 1'b1; break; end
      end
      if (!seen || sbq.size() == 0) begin
         checks++; errors++;
         $display("FAIL %s_timeout: got no done/expectation expected done within 200 cycles", name);
         sbq.delete();
         return;
      end
      e = sbq.pop_front();
      chk({name, "_latency"}, W'(k), W'(e.lat));
      chk({name, "_busy_cycles"}, W'(nb), W'(e.bsy));
      chk({name, "_hi"}, hi, e.hi);
      chk({name, "_lo"}, lo, e.lo);
   endtask

   vec_t vecs[$];

   initial begin
      int ndone;
      logic [W-1:0] prev_hi;
      errors = 0; checks = 0;
      m_hi = '0; m_lo = '0;
      rst_n = 1'b0; start = 1'b0; op = 2'b00; rs_val = '0; rt_val = '0;
      hi_we = 1'b0; lo_we = 1'b0; wd = '0;

      // op, rs, rt, expected hi, expected lo
      vecs.push_back('{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001});
      vecs.push_back('{2'b01, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1});
      vecs.push_back('{2'b11, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD});
      vecs.push_back('{2'b10, 32'h00000064, 32'h00000000, 32'h00000064, 32'hFFFFFFFF});
      vecs.push_back('{2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000});
      vecs.push_back('{2'b10, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E});
      vecs.push_back('{2'b00, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780});
      vecs.push_back('{2'b11, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD});
      vecs.push_back('{2'b01, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000});
      vecs.push_back('{2'b11, 32'hFFFFFFF6, 32'h00000000, 32'hFFFFFFF6, 32'hFFFFFFFF});
      vecs.push_back('{2'b10, 32'h0000000A, 32'h00000003, 32'h00000001, 32'h00000003});
      vecs.push_back('{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001});

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_hi", hi, '0);
      chk("rst_lo", lo, '0);
      chk("rst_busy", W'(busy), '0);
      chk("rst_done", W'(done), '0);
      rst_n = 1'b1;
      @(negedge clk);

      // MTHI / MTLO in IDLE
      hi_we = 1'b1; wd = 32'h12345678;
      @(posedge clk); #1 hi_we = 1'b0;
      @(negedge clk);
      chk("mthi", hi, 32'h12345678);
      m_hi = 32'h12345678;
      lo_we = 1'b1; wd = 32'h9ABCDEF0;
      @(posedge clk); #1 lo_we = 1'b0;
      @(negedge clk);
      chk("mtlo", lo, 32'h9ABCDEF0);
      m_lo = 32'h9ABCDEF0;

      // Table of operations
      foreach (vecs[i]) begin
         launch(vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].ehi, vecs[i].elo);
         finish_op($sformatf("vec%0d", i));
         @(negedge clk);
         chk($sformatf("vec%0d_done_one_cycle", i), W'(done), '0);
      end

      // Back-to-back: second start in the cycle done is high
      launch(2'b00, 32'd3, 32'd4, 32'd0, 32'd12);
      finish_op("b2b_a");
      launch(2'b01, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFA);
      finish_op("b2b_b");
      @(negedge clk);

      // MTHI and start arrive together: the write lands, then the result overwrites it
      hi_we = 1'b1; wd = 32'h0000AAAA;
      launch(2'b00, 32'd2, 32'd3, 32'd0, 32'd6);
      hi_we = 1'b0;
      fork
         begin @(negedge clk); chk("mthi_with_start", hi, 32'h0000AAAA); end
         finish_op("mthi_start_op");
      join
      @(negedge clk);

      // While busy, MTHI is ignored and a second start is ignored
      prev_hi = hi;
      launch(2'b00, 32'd7, 32'd9, 32'd0, 32'd63);
      fork
         begin
            repeat (5) @(negedge clk);
            hi_we = 1'b1; wd = 32'hDEADBEEF;
            start = 1'b1; op = 2'b00; rs_val = 32'd5; rt_val = 32'd5;
            @(negedge clk);
            chk("mthi_while_busy", hi, prev_hi);
            hi_we = 1'b0; start = 1'b0;
         end
         finish_op("busy_ignore");
      join
      ndone = 0;
      repeat (40) begin @(negedge clk); if (done) ndone++; end
      chk("no_extra_done", W'(ndone), '0);

      // Reset in the middle of an operation
      launch(2'b00, 32'd7, 32'd9, 32'd0, 32'd63);
      repeat (9) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midrst_hi", hi, '0);
      chk("midrst_lo", lo, '0);
      chk("midrst_busy", W'(busy), '0);
      sbq.delete(); m_hi = '0; m_lo = '0;
      @(negedge clk);
      rst_n = 1'b1;
      ndone = 0;
      repeat (40) begin @(negedge clk); if (done) ndone++; end
      chk("midrst_no_done", W'(ndone), '0);
      chk("midrst_hi_after", hi, '0);
      launch(2'b00, 32'd2, 32'd3, 32'd0, 32'd6);
      finish_op("after_rst");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Hard time limit. This only trips if the main sequence is stuck.
   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end
endmodule
